// File: rtl/gpio_bsr_if.sv
`default_nettype none
// ============================================================================
//  Module      : gpio_bsr_if
//  Description : TAP-to-boundary-scan-register link. Carries the TAP's
//                decoded DR-phase strobes, instruction selects and serial
//                data in, and returns the chain's serial output.
//  Revision    : 1.0  initial release
// ============================================================================
interface gpio_bsr_if;
    logic tlr;          // TAP in TEST_LOGIC_RESET (level)
    logic capture_dr;   // TAP in CAPTURE_DR
    logic shift_dr;     // TAP in SHIFT_DR
    logic update_dr;    // TAP in UPDATE_DR
    logic sel_sample;   // SAMPLE/PRELOAD instruction active
    logic sel_extest;   // EXTEST instruction active
    logic sel_clamp;    // CLAMP instruction active
    logic tdi;          // serial data into the chain
    logic bsr_tdo;      // serial data out of the chain (bit 0)

    // TAP side
    modport master (
        output tlr, capture_dr, shift_dr, update_dr,
        output sel_sample, sel_extest, sel_clamp, tdi,
        input  bsr_tdo
    );

    // Boundary-scan register side
    modport slave (
        input  tlr, capture_dr, shift_dr, update_dr,
        input  sel_sample, sel_extest, sel_clamp, tdi,
        output bsr_tdo
    );
endinterface
`default_nettype wire

// File: rtl/gpio_bsr.sv
`default_nettype none
// ============================================================================
//  Module      : gpio_bsr
//  Description : Boundary-scan register chain for the GPIO pads. Three cells
//                per pad (input, output, output-enable); bit 0 sits nearest
//                TDO. Supports SAMPLE/PRELOAD, EXTEST and CLAMP.
//  Revision    : 1.0  initial release
// ============================================================================
module gpio_bsr #(
    parameter int N_GPIO = 8
) (
    input  logic              tclk,
    input  logic              trst,
    gpio_bsr_if.slave         tap,
    input  logic [N_GPIO-1:0] core_out,
    input  logic [N_GPIO-1:0] core_oe,
    output logic [N_GPIO-1:0] core_in,
    input  logic [N_GPIO-1:0] pad_in,
    output logic [N_GPIO-1:0] pad_out,
    output logic [N_GPIO-1:0] pad_oe
);

    localparam int CHAIN_LEN = 3 * N_GPIO;

    // Shift stage, clocked on the rising edge of tclk.
    logic [CHAIN_LEN-1:0] sr;

    // Update stage, clocked on the falling edge of tclk. Only the output and
    // output-enable cells have an update stage: the input-cell update bit
    // never reaches a pad or the capture path, so it is not kept.
    logic [N_GPIO-1:0] upd_out;
    logic [N_GPIO-1:0] upd_oe;

    logic                 chain_sel;
    logic                 test_mode;
    logic [CHAIN_LEN-1:0] cap_vec;
    logic [N_GPIO-1:0]    sr_out;
    logic [N_GPIO-1:0]    sr_oe;

    assign chain_sel = tap.sel_sample | tap.sel_extest;
    assign test_mode = (tap.sel_extest | tap.sel_clamp) & ~tap.tlr;

    // Per-pad capture values and views of the output/oe shift cells.
    // EXTEST takes precedence over SAMPLE when both selects are set, so the
    // output/oe cells read back what the pads are actually being driven with.
    generate
        for (genvar i = 0; i < N_GPIO; i++) begin : g_cell
            assign cap_vec[3*i]   = pad_in[i];
            assign cap_vec[3*i+1] = tap.sel_extest ? upd_out[i] : core_out[i];
            assign cap_vec[3*i+2] = tap.sel_extest ? upd_oe[i]  : core_oe[i];
            assign sr_out[i]      = sr[3*i+1];
            assign sr_oe[i]       = sr[3*i+2];
        end
    endgenerate

    // Shift register: TLR clear, then capture over shift, only while selected.
    always_ff @(posedge tclk or negedge trst) begin
        if (!trst) begin
            sr <= '0;
        end else if (tap.tlr) begin
            sr <= '0;
        end else if (chain_sel) begin
            if (tap.capture_dr) begin
                sr <= cap_vec;
            end else if (tap.shift_dr) begin
                sr <= {tap.tdi, sr[CHAIN_LEN-1:1]};
            end
        end
    end

    // Update register: loads on the falling edge so pads change half a cycle
    // after UPDATE_DR, never while the shift stage is moving.
    always_ff @(negedge tclk or negedge trst) begin
        if (!trst) begin
            upd_out <= '0;
            upd_oe  <= '0;
        end else if (tap.tlr) begin
            upd_out <= '0;
            upd_oe  <= '0;
        end else if (tap.update_dr && chain_sel) begin
            upd_out <= sr_out;
            upd_oe  <= sr_oe;
        end
    end

    // Pad mux: test instructions drive the update stage onto the pads;
    // the functional input path to the core is never blocked.
    always_comb begin
        pad_out = test_mode ? upd_out : core_out;
        pad_oe  = test_mode ? upd_oe  : core_oe;
        core_in = pad_in;
    end

    assign tap.bsr_tdo = sr[0];

endmodule
`default_nettype wire

// File: tb/tb_gpio_bsr.sv
`default_nettype none
// ============================================================================
//  Module      : tb_gpio_bsr
//  Description : Self-checking bench for gpio_bsr: directed vector table,
//                hand-written scan sequences, and randomized cycles checked
//                against a queue-based chain model.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_gpio_bsr;

    localparam int N = 8;
    localparam int L = 3 * N;

    logic         tclk = 1'b0;
    logic         trst = 1'b0;
    logic [N-1:0] core_out = '0, core_oe = '0, pad_in = '0;
    logic [N-1:0] core_in, pad_out, pad_oe;

    gpio_bsr_if tap_if ();

    gpio_bsr #(.N_GPIO(N)) dut (
        .tclk     (tclk),
        .trst     (trst),
        .tap      (tap_if),
        .core_out (core_out),
        .core_oe  (core_oe),
        .core_in  (core_in),
        .pad_in   (pad_in),
        .pad_out  (pad_out),
        .pad_oe   (pad_oe)
    );

    always #5 tclk = ~tclk;

    int checks = 0;
    int errors = 0;

    // Reference model: chain as a queue, element 0 nearest TDO; update
    // register as a plain array copy of the chain.
    bit m_sr[$];
    bit m_upd[L];

    // Control word order: {tlr, capture, shift, update, sample, extest, clamp, tdi}
    typedef struct {
        logic [7:0]   ctl;
        logic [N-1:0] pin;
        logic [N-1:0] cout;
        logic [N-1:0] coe;
        logic         etdo;
        logic [N-1:0] epo;
        logic [N-1:0] epoe;
    } vec_t;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    task automatic apply_ctl(input logic [7:0] c);
        tap_if.tlr        = c[7];
        tap_if.capture_dr = c[6];
        tap_if.shift_dr   = c[5];
        tap_if.update_dr  = c[4];
        tap_if.sel_sample = c[3];
        tap_if.sel_extest = c[2];
        tap_if.sel_clamp  = c[1];
        tap_if.tdi        = c[0];
    endtask

    function automatic void m_reset();
        m_sr.delete();
        for (int k = 0; k < L; k++) begin
            m_sr.push_back(1'b0);
            m_upd[k] = 1'b0;
        end
    endfunction

    function automatic void model_pos();
        if (tap_if.tlr) begin
            foreach (m_sr[k]) m_sr[k] = 1'b0;
        end else if (tap_if.sel_sample || tap_if.sel_extest) begin
            if (tap_if.capture_dr) begin
                for (int i = 0; i < N; i++) begin
                    m_sr[3*i]   = pad_in[i];
                    m_sr[3*i+1] = tap_if.sel_extest ? m_upd[3*i+1] : core_out[i];
                    m_sr[3*i+2] = tap_if.sel_extest ? m_upd[3*i+2] : core_oe[i];
                end
            end else if (tap_if.shift_dr) begin
                void'(m_sr.pop_front());
                m_sr.push_back(tap_if.tdi);
            end
        end
    endfunction

    function automatic void model_neg();
        if (tap_if.tlr) begin
            for (int k = 0; k < L; k++) m_upd[k] = 1'b0;
        end else if (tap_if.update_dr && (tap_if.sel_sample || tap_if.sel_extest)) begin
            for (int k = 0; k < L; k++) m_upd[k] = m_sr[k];
        end
    endfunction

    function automatic logic [N-1:0] exp_pad(input bit want_oe);
        logic [N-1:0] r;
        bit tm;
        tm = (tap_if.sel_extest || tap_if.sel_clamp) && !tap_if.tlr;
        for (int i = 0; i < N; i++) begin
            if (tm) r[i] = m_upd[3*i + (want_oe ? 2 : 1)];
            else    r[i] = want_oe ? core_oe[i] : core_out[i];
        end
        return r;
    endfunction

    // One full tclk period; returns just after the falling edge.
    task automatic step();
        @(posedge tclk);
        model_pos();
        @(negedge tclk);
        model_neg();
        #1;
    endtask

    task automatic chk_model(input string nm);
        chk({nm, ".tdo"},     32'(tap_if.bsr_tdo), 32'(m_sr[0]));
        chk({nm, ".pad_out"}, 32'(pad_out), 32'(exp_pad(1'b0)));
        chk({nm, ".pad_oe"},  32'(pad_oe),  32'(exp_pad(1'b1)));
        chk({nm, ".core_in"}, 32'(core_in), 32'(pad_in));
    endtask

    function automatic logic [L-1:0] build_chain(input logic [N-1:0] o, input logic [N-1:0] e);
        logic [L-1:0] v;
        v = '0;
        for (int i = 0; i < N; i++) begin
            v[3*i+1] = o[i];
            v[3*i+2] = e[i];
        end
        return v;
    endfunction

    // SAMPLE/PRELOAD shift of a full chain image followed by UPDATE_DR.
    task automatic preload(input logic [L-1:0] v);
        for (int k = 0; k < L; k++) begin
            apply_ctl({4'b0010, 4'b1000} | {7'b0, v[k]});
            step();
            chk_model("preload_shift");
        end
        apply_ctl(8'b0001_1000);
        step();
        chk("preload_pads_out", 32'(pad_out), 32'(core_out));
        chk("preload_pads_oe",  32'(pad_oe),  32'(core_oe));
    endtask

    vec_t tbl[10];

    initial begin
        logic [L-1:0] img;
        logic         held_tdo;

        tbl[0] = '{8'b0000_0000, 8'h00, 8'h3C, 8'hFF, 1'b0, 8'h3C, 8'hFF};
        tbl[1] = '{8'b0100_1000, 8'h81, 8'h0F, 8'hF0, 1'b1, 8'h0F, 8'hF0};
        tbl[2] = '{8'b0010_1000, 8'h81, 8'h0F, 8'hF0, 1'b1, 8'h0F, 8'hF0};
        tbl[3] = '{8'b0010_1000, 8'h81, 8'h0F, 8'hF0, 1'b0, 8'h0F, 8'hF0};
        tbl[4] = '{8'b0010_1000, 8'h81, 8'h0F, 8'hF0, 1'b0, 8'h0F, 8'hF0};
        tbl[5] = '{8'b0010_1000, 8'h81, 8'h0F, 8'hF0, 1'b1, 8'h0F, 8'hF0};
        tbl[6] = '{8'b0010_1000, 8'h81, 8'h0F, 8'hF0, 1'b0, 8'h0F, 8'hF0};
        tbl[7] = '{8'b0000_0100, 8'h81, 8'h0F, 8'hF0, 1'b0, 8'h00, 8'h00};
        tbl[8] = '{8'b0000_0010, 8'h81, 8'h0F, 8'hF0, 1'b0, 8'h00, 8'h00};
        tbl[9] = '{8'b1000_0010, 8'h81, 8'h0F, 8'hF0, 1'b0, 8'h0F, 8'hF0};

        // Reset state
        apply_ctl(8'h00);
        core_out = 8'h3C; core_oe = 8'hFF; pad_in = 8'h00;
        m_reset();
        #2;
        chk("reset.tdo",     32'(tap_if.bsr_tdo), 32'd0);
        chk("reset.pad_out", 32'(pad_out), 32'h3C);
        chk("reset.pad_oe",  32'(pad_oe),  32'hFF);
        #10;
        trst = 1'b1;

        // Directed vector table
        for (int v = 0; v < 10; v++) begin
            apply_ctl(tbl[v].ctl);
            pad_in = tbl[v].pin; core_out = tbl[v].cout; core_oe = tbl[v].coe;
            step();
            chk($sformatf("vec%0d.tdo", v),     32'(tap_if.bsr_tdo), 32'(tbl[v].etdo));
            chk($sformatf("vec%0d.pad_out", v), 32'(pad_out), 32'(tbl[v].epo));
            chk($sformatf("vec%0d.pad_oe", v),  32'(pad_oe),  32'(tbl[v].epoe));
        end

        // SAMPLE: capture then read the full chain, pads untouched throughout
        pad_in = 8'h81; core_out = 8'h0F; core_oe = 8'hF0;
        apply_ctl(8'b0100_1000);
        step();
        for (int k = 0; k < L; k++) begin
            logic [N-1:0] src;
            src = (k % 3 == 0) ? 8'h81 : (k % 3 == 1) ? 8'h0F : 8'hF0;
            chk($sformatf("sample_bit%0d", k), 32'(tap_if.bsr_tdo), 32'(src[k/3]));
            chk("sample_pads", 32'({pad_out, pad_oe}), 32'({8'h0F, 8'hF0}));
            apply_ctl(8'b0010_1000);
            step();
        end

        // PRELOAD 0x55 / 0xFF then switch to EXTEST
        core_out = 8'h3C; core_oe = 8'h00;
        preload(build_chain(8'h55, 8'hFF));
        apply_ctl(8'b0000_0100);
        #1;
        chk("extest_drive_out", 32'(pad_out), 32'h55);
        chk("extest_drive_oe",  32'(pad_oe),  32'hFF);
        step();
        chk_model("extest_idle");

        // EXTEST capture: output/oe cells read back update stage
        pad_in = 8'hC3;
        apply_ctl(8'b0100_0100);
        step();
        for (int k = 0; k < L; k++) begin
            logic [N-1:0] src;
            src = (k % 3 == 0) ? 8'hC3 : (k % 3 == 1) ? 8'h55 : 8'hFF;
            chk($sformatf("extest_bit%0d", k), 32'(tap_if.bsr_tdo), 32'(src[k/3]));
            apply_ctl(8'b0010_0100);
            step();
        end
        chk("extest_pads_hold", 32'({pad_out, pad_oe}), 32'({8'h55, 8'hFF}));

        // CLAMP after PRELOAD of 0xAA; strobes without chain select are inert
        preload(build_chain(8'hAA, 8'hFF));
        apply_ctl(8'b0000_0010);
        step();
        chk("clamp_out", 32'(pad_out), 32'hAA);
        chk("clamp_oe",  32'(pad_oe),  32'hFF);
        held_tdo = tap_if.bsr_tdo;
        for (int k = 0; k < 4; k++) begin
            apply_ctl((k % 2 == 0) ? 8'b0011_0011 : 8'b0101_0010);
            step();
            chk("clamp_hold_tdo", 32'(tap_if.bsr_tdo), 32'(held_tdo));
            chk("clamp_hold_out", 32'(pad_out), 32'hAA);
            chk_model("clamp_hold");
        end

        // TLR while EXTEST drives 0x55
        preload(build_chain(8'h55, 8'hFF));
        apply_ctl(8'b0000_0100);
        step();
        chk("tlr_pre_out", 32'(pad_out), 32'h55);
        apply_ctl(8'b1000_0100);
        #1;
        chk("tlr_pads_out", 32'(pad_out), 32'(core_out));
        chk("tlr_pads_oe",  32'(pad_oe),  32'(core_oe));
        step();
        chk("tlr_tdo", 32'(tap_if.bsr_tdo), 32'd0);
        apply_ctl(8'b0000_0100);
        #1;
        chk("tlr_upd_cleared", 32'({pad_out, pad_oe}), 32'd0);
        step();

        // trst in the middle of shifting 0xA5 pattern
        core_out = 8'h3C; core_oe = 8'hFF;
        preload(build_chain(8'h55, 8'hFF));
        img = {3{8'hA5}};
        for (int k = 0; k < 12; k++) begin
            apply_ctl({4'b0010, 4'b1000} | {7'b0, img[k]});
            step();
        end
        #1;
        trst = 1'b0;
        m_reset();
        #1;
        chk("trst_tdo",     32'(tap_if.bsr_tdo), 32'd0);
        chk("trst_pad_out", 32'(pad_out), 32'h3C);
        chk("trst_pad_oe",  32'(pad_oe),  32'hFF);
        trst = 1'b1;
        apply_ctl(8'b0000_0100);
        #1;
        chk("trst_upd_cleared", 32'({pad_out, pad_oe}), 32'd0);
        step();
        chk_model("trst_after");

        // Randomized cycles against the model
        for (int c = 0; c < 400; c++) begin
            logic [7:0] ctl;
            ctl = 8'($urandom);
            ctl[7] = ($urandom_range(0, 19) == 0);
            apply_ctl(ctl);
            pad_in = 8'($urandom); core_out = 8'($urandom); core_oe = 8'($urandom);
            step();
            chk_model($sformatf("rand%0d", c));
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
`default_nettype wire
